// File: rtl/pipe_register.sv
// Elastic pipeline of DEPTH valid/ready stages with forward compaction into bubbles.
// Asynchronous active-low reset, synchronous clear; out_ready reaches in_ready combinationally.
module pipe_register #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] d_reg [DEPTH];
  logic [DEPTH-1:0] v_reg;
  logic [CW-1:0]    count_reg;

  logic [WIDTH-1:0] src_data [DEPTH];
  logic [DEPTH-1:0] src_valid;
  logic [DEPTH-1:0] can_load;
  logic [DEPTH-1:0] unload;
  // take[DEPTH] is the downstream transfer; it seeds the backward ready chain
  logic [DEPTH:0]   take;
  logic             in_xfer;
  logic             out_xfer;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign src_valid[gi] = in_valid;
        assign src_data[gi]  = in_data;
      end else begin : g_body
        assign src_valid[gi] = v_reg[gi-1];
        assign src_data[gi]  = d_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    can_load     = '0;
    unload       = '0;
    take         = '0;
    take[DEPTH]  = v_reg[DEPTH-1] & out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      unload[i]   = take[i+1];
      can_load[i] = ~v_reg[i] | unload[i];
      take[i]     = can_load[i] & src_valid[i];
    end
  end

  assign in_ready  = rst & ~clear & can_load[0];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = take[DEPTH];
  assign out_valid = v_reg[DEPTH-1];
  assign out_data  = d_reg[DEPTH-1];
  assign count     = count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_reg <= '0;
      for (int i = 0; i < DEPTH; i++) d_reg[i] <= RESET_VAL;
    end else if (clear) begin
      v_reg <= '0;
      for (int i = 0; i < DEPTH; i++) d_reg[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (take[i]) begin
          d_reg[i] <= src_data[i];
          v_reg[i] <= 1'b1;
        end else if (unload[i]) begin
          v_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Simultaneous in and out leave the occupancy unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (in_xfer && !out_xfer) begin
      count_reg <= count_reg + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_register.sv
// Directed bench for pipe_register (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
// One cycle per call: drive after the rising edge, observe at mid-cycle.
module tb_pipe_register;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] count;

  int errors = 0;
  int checks = 0;

  pipe_register #(
    .WIDTH(8),
    .DEPTH(3),
    .RESET_VAL(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the next one.
  task automatic cyc(input string tag, input logic iv, input logic [7:0] id,
                     input logic ordy, input logic clr,
                     input logic e_ir, input logic e_ov, input logic e_chkd,
                     input logic [7:0] e_d, input logic [1:0] e_cnt);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clear     = clr;
    #4;
    $display("txn %s iv=%0d id=%h ordy=%0d clr=%0d | ir=%0d ov=%0d od=%h cnt=%0d",
             tag, iv, id, ordy, clr, in_ready, out_valid, out_data, count);
    check({tag, "/in_ready"}, 32'(in_ready), 32'(e_ir));
    check({tag, "/out_valid"}, 32'(out_valid), 32'(e_ov));
    check({tag, "/count"}, 32'(count), 32'(e_cnt));
    if (e_chkd) check({tag, "/out_data"}, 32'(out_data), 32'(e_d));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Held in reset
    repeat (2) @(posedge clk);
    #1;
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/out_data", 32'(out_data), 32'hA5);
    check("rst/count", 32'(count), 32'd0);
    check("rst/in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    cyc("idle", 0, 8'h00, 0, 0, 1, 0, 1, 8'hA5, 2'd0);

    // Stream 01..10 with out_ready=1: three-cycle latency, no gaps
    for (int c = 0; c < 20; c++) begin
      int n_in;
      int n_out;
      logic ev;
      n_in  = (c < 16) ? c : 16;
      n_out = (c > 3) ? c - 3 : 0;
      ev    = (c >= 3) && (c < 19);
      cyc($sformatf("s%0d", c), c < 16, 8'(c + 1), 1, 0,
          1, ev, ev, 8'(c - 2), 2'(n_in - n_out));
    end

    // Backpressure: 44 held until out_ready returns
    cyc("q0", 1, 8'h11, 0, 0, 1, 0, 0, 8'h00, 2'd0);
    cyc("q1", 1, 8'h22, 0, 0, 1, 0, 0, 8'h00, 2'd1);
    cyc("q2", 1, 8'h33, 0, 0, 1, 0, 0, 8'h00, 2'd2);
    cyc("q3", 1, 8'h44, 0, 0, 0, 1, 1, 8'h11, 2'd3);
    cyc("q4", 1, 8'h44, 0, 0, 0, 1, 1, 8'h11, 2'd3);
    cyc("q5", 1, 8'h44, 1, 0, 1, 1, 1, 8'h11, 2'd3);
    cyc("q6", 0, 8'h00, 1, 0, 1, 1, 1, 8'h22, 2'd3);
    cyc("q7", 0, 8'h00, 1, 0, 1, 1, 1, 8'h33, 2'd2);
    cyc("q8", 0, 8'h00, 1, 0, 1, 1, 1, 8'h44, 2'd1);
    cyc("q9", 0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 2'd0);

    // Full pipe with simultaneous in/out for 5 cycles
    cyc("f0", 1, 8'hA0, 0, 0, 1, 0, 0, 8'h00, 2'd0);
    cyc("f1", 1, 8'hA1, 0, 0, 1, 0, 0, 8'h00, 2'd1);
    cyc("f2", 1, 8'hA2, 0, 0, 1, 0, 0, 8'h00, 2'd2);
    cyc("f3", 1, 8'hB0, 1, 0, 1, 1, 1, 8'hA0, 2'd3);
    cyc("f4", 1, 8'hB1, 1, 0, 1, 1, 1, 8'hA1, 2'd3);
    cyc("f5", 1, 8'hB2, 1, 0, 1, 1, 1, 8'hA2, 2'd3);
    cyc("f6", 1, 8'hB3, 1, 0, 1, 1, 1, 8'hB0, 2'd3);
    cyc("f7", 1, 8'hB4, 1, 0, 1, 1, 1, 8'hB1, 2'd3);
    cyc("f8", 0, 8'h00, 0, 0, 0, 1, 1, 8'hB2, 2'd3);
    cyc("f9", 0, 8'h00, 1, 0, 1, 1, 1, 8'hB2, 2'd3);
    cyc("f10", 0, 8'h00, 1, 0, 1, 1, 1, 8'hB3, 2'd2);
    cyc("f11", 0, 8'h00, 1, 0, 1, 1, 1, 8'hB4, 2'd1);
    cyc("f12", 0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 2'd0);

    // Clear with two words in flight and 55 offered: nothing emerges
    cyc("c0", 1, 8'hC1, 0, 0, 1, 0, 0, 8'h00, 2'd0);
    cyc("c1", 1, 8'hC2, 0, 0, 1, 0, 0, 8'h00, 2'd1);
    cyc("c2", 1, 8'h55, 0, 1, 0, 0, 0, 8'h00, 2'd2);
    cyc("c3", 0, 8'h00, 1, 0, 1, 0, 1, 8'hA5, 2'd0);
    cyc("c4", 0, 8'h00, 1, 0, 1, 0, 1, 8'hA5, 2'd0);
    cyc("c5", 0, 8'h00, 1, 0, 1, 0, 1, 8'hA5, 2'd0);
    cyc("c6", 0, 8'h00, 1, 0, 1, 0, 1, 8'hA5, 2'd0);

    // Asynchronous reset between edges with two words held
    cyc("r0", 1, 8'hD1, 0, 0, 1, 0, 0, 8'h00, 2'd0);
    cyc("r1", 1, 8'hD2, 0, 0, 1, 0, 0, 8'h00, 2'd1);
    in_valid = 1'b0;
    #1;
    check("r2/count", 32'(count), 32'd2);
    #1;
    rst = 1'b0;
    #1;
    $display("txn areset ir=%0d ov=%0d od=%h cnt=%0d", in_ready, out_valid, out_data, count);
    check("areset/count", 32'(count), 32'd0);
    check("areset/out_valid", 32'(out_valid), 32'd0);
    check("areset/in_ready", 32'(in_ready), 32'd0);
    check("areset/out_data", 32'(out_data), 32'hA5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("e0", 1, 8'hE1, 1, 0, 1, 0, 0, 8'h00, 2'd0);
    cyc("e1", 1, 8'hE2, 1, 0, 1, 0, 0, 8'h00, 2'd1);
    cyc("e2", 0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 2'd2);
    cyc("e3", 0, 8'h00, 1, 0, 1, 1, 1, 8'hE1, 2'd2);
    cyc("e4", 0, 8'h00, 1, 0, 1, 1, 1, 8'hE2, 2'd1);
    cyc("e5", 0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 2'd0);
    cyc("e6", 0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
